// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice scheduler. It maps key-on/key-off events from the keyboard
// decoder onto NUM_VOICES voice slots. For each slot it drives the envelope
// gate and the key code. It reclaims a releasing voice once its envelope
// reports idle. When every slot is busy it reuses the oldest releasing voice.
// If there is none, it steals the least-recently-used held voice.
//
// Build option: define VOICE_STEAL_EN to enable stealing.
//   - With stealing, the victim's gate is held low for STEAL_GAP cycles before
//     it is retriggered with the new key.
//   - Without stealing, a key-on with every voice held is dropped.
//
// Ports
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   key_valid     key event present
//   key_on        1 = key-on, 0 = key-off
//   key_code      key of the event
//   key_ready     event accepted when key_valid & key_ready at posedge Clk
//   env_idle      per-voice envelope magnitude == 0
//   voice_gate    per-voice keypress to the envelope generator
//   voice_key     per-voice key code, voice i at [i*KEY_W +: KEY_W]
//   voice_retrig  one-cycle pulse when a voice gets a new key
//   steal_pulse   one-cycle pulse when a held voice is stolen
//   drop_pulse    one-cycle pulse when a key-on is discarded
//   active_count  number of voices not FREE
//
// Handshake: an event is consumed on the rising edge where key_valid and
// key_ready are both 1. Its effect appears on the outputs from that edge on.
// key_valid must not depend on key_ready.
// ----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 6,
    parameter int STEAL_GAP  = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            key_valid,
    input  logic                            key_on,
    input  logic [KEY_W-1:0]                key_code,
    output logic                            key_ready,
    input  logic [NUM_VOICES-1:0]           env_idle,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic [NUM_VOICES*KEY_W-1:0]     voice_key,
    output logic [NUM_VOICES-1:0]           voice_retrig,
    output logic                            steal_pulse,
    output logic                            drop_pulse,
    output logic [$clog2(NUM_VOICES+1)-1:0] active_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACT_W = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {
        V_FREE = 2'd0,
        V_HELD = 2'd1,
        V_REL  = 2'd2
    } voice_state_t;

    voice_state_t          state_q [NUM_VOICES];
    voice_state_t          state_d [NUM_VOICES];
    logic [KEY_W-1:0]      key_q   [NUM_VOICES];
    logic [KEY_W-1:0]      key_d   [NUM_VOICES];
    // LRU age: 0 = most recently assigned. Ages are always a permutation.
    logic [IDX_W-1:0]      age_q   [NUM_VOICES];
    logic [IDX_W-1:0]      age_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] retrig_q, retrig_d;
    logic [ACT_W-1:0]      active_q, active_d;

    logic                  accept;
    logic                  hit_found;
    logic [IDX_W-1:0]      hit_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  rel_found;
    logic [IDX_W-1:0]      rel_idx;
    logic [IDX_W-1:0]      rel_age;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  upd_en;
    logic [IDX_W-1:0]      upd_idx;

`ifdef VOICE_STEAL_EN
    localparam int CNT_W = $clog2(STEAL_GAP + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUTE = 1'b1
    } fsm_state_t;

    // fsm_state is the allocator FSM state, exposed for checkers.
    fsm_state_t            fsm_state, fsm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      victim_q, victim_d;
    logic [KEY_W-1:0]      pend_q, pend_d;
    logic                  ready_q, ready_d;
    logic                  steal_q, steal_d;
    logic                  held_found;
    logic [IDX_W-1:0]      held_idx;
    logic [IDX_W-1:0]      held_age;
`else
    logic                  drop_q, drop_d;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign voice_gate   = gate_q;
    assign voice_retrig = retrig_q;
    assign active_count = active_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
        assign voice_key[g*KEY_W +: KEY_W] = key_q[g];
    end

`ifdef VOICE_STEAL_EN
    assign key_ready   = ready_q;
    assign steal_pulse = steal_q;
    assign drop_pulse  = 1'b0;
`else
    assign key_ready   = 1'b1;
    assign steal_pulse = 1'b0;
    assign drop_pulse  = drop_q;
`endif

    assign accept = key_valid & key_ready;

    // ------------------------------------------------------------------
    // Voice searches over the registered state
    // ------------------------------------------------------------------
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        rel_age    = '0;
`ifdef VOICE_STEAL_EN
        held_found = 1'b0;
        held_idx   = '0;
        held_age   = '0;
`endif
        // Walk downwards so the last FREE voice found is the lowest index.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (state_q[i] == V_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            // Keys are unique among held voices, so at most one match.
            if (state_q[i] == V_HELD && key_q[i] == key_code) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (state_q[i] == V_REL && (!rel_found || age_q[i] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
                rel_age   = age_q[i];
            end
`ifdef VOICE_STEAL_EN
            if (state_q[i] == V_HELD && (!held_found || age_q[i] > held_age)) begin
                held_found = 1'b1;
                held_idx   = IDX_W'(i);
                held_age   = age_q[i];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        age_d     = age_q;
        gate_d    = gate_q;
        retrig_d  = '0;
        active_d  = '0;
        alloc_idx = '0;
        upd_en    = 1'b0;
        upd_idx   = '0;
`ifdef VOICE_STEAL_EN
        fsm_d     = fsm_state;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        pend_d    = pend_q;
        ready_d   = ready_q;
        steal_d   = 1'b0;
`else
        drop_d    = 1'b0;
`endif

        // Reclaim first. An allocation below to the same voice overrides it.
        // The steal victim is HELD, so it is never reclaimed while muted.
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (state_q[i] == V_REL && env_idle[i]) begin
                state_d[i] = V_FREE;
            end
        end

`ifdef VOICE_STEAL_EN
        if (fsm_state == S_MUTE) begin
            // key_ready is low here, so no event can be accepted.
            if (cnt_q == '0) begin
                key_d[victim_q]    = pend_q;
                gate_d[victim_q]   = 1'b1;
                retrig_d[victim_q] = 1'b1;
                upd_en             = 1'b1;
                upd_idx            = victim_q;
                ready_d            = 1'b1;
                fsm_d              = S_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else
`endif
        if (accept) begin
            if (key_on) begin
                if (hit_found) begin
                    // Same key already sounding: retrigger in place, LRU untouched.
                    retrig_d[hit_idx] = 1'b1;
                end else if (free_found || rel_found) begin
                    alloc_idx            = free_found ? free_idx : rel_idx;
                    state_d[alloc_idx]   = V_HELD;
                    key_d[alloc_idx]     = key_code;
                    gate_d[alloc_idx]    = 1'b1;
                    retrig_d[alloc_idx]  = 1'b1;
                    upd_en               = 1'b1;
                    upd_idx              = alloc_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    // Every voice is held. Mute the oldest one, then retrigger it
                    // after the gap. The victim stays HELD for counting purposes.
                    gate_d[held_idx] = 1'b0;
                    steal_d          = 1'b1;
                    ready_d          = 1'b0;
                    victim_d         = held_idx;
                    pend_d           = key_code;
                    cnt_d            = CNT_W'(STEAL_GAP - 1);
                    fsm_d            = S_MUTE;
`else
                    drop_d = 1'b1;
`endif
                end
            end else if (hit_found) begin
                state_d[hit_idx] = V_REL;
                gate_d[hit_idx]  = 1'b0;
            end
        end

        // LRU move-to-front: voices younger than the assigned one age by one.
        if (upd_en) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == upd_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[upd_idx]) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
        end

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (state_d[i] != V_FREE) begin
                active_d = active_d + ACT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= V_FREE;
                key_q[i]   <= '0;
                age_q[i]   <= IDX_W'(i);
            end
            gate_q   <= '0;
            retrig_q <= '0;
            active_q <= '0;
`ifdef VOICE_STEAL_EN
            fsm_state <= S_IDLE;
            cnt_q     <= '0;
            victim_q  <= '0;
            pend_q    <= '0;
            ready_q   <= 1'b1;
            steal_q   <= 1'b0;
`else
            drop_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            age_q    <= age_d;
            gate_q   <= gate_d;
            retrig_q <= retrig_d;
            active_q <= active_d;
`ifdef VOICE_STEAL_EN
            fsm_state <= fsm_d;
            cnt_q     <= cnt_d;
            victim_q  <= victim_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            steal_q   <= steal_d;
`else
            drop_q    <= drop_d;
`endif
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// ----------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed bench for voice_allocator with NUM_VOICES=4, KEY_W=6, STEAL_GAP=4.
// A behavioural model keeps the voice states, the keys and an LRU list of
// voice indices (most recent first). After every rising edge it computes the
// expected outputs. A compare process checks the DUT against the model on
// every falling edge. Literal checks in the stimulus pin the model itself.
// ----------------------------------------------------------------------------
module tb_voice_allocator;
    localparam int NV  = 4;
    localparam int KW  = 6;
    localparam int GAP = 4;

    localparam int M_FREE = 0;
    localparam int M_HELD = 1;
    localparam int M_REL  = 2;

    logic              Clk;
    logic              Reset;
    logic              key_valid;
    logic              key_on;
    logic [KW-1:0]     key_code;
    logic              key_ready;
    logic [NV-1:0]     env_idle;
    logic [NV-1:0]     voice_gate;
    logic [NV*KW-1:0]  voice_key;
    logic [NV-1:0]     voice_retrig;
    logic              steal_pulse;
    logic              drop_pulse;
    logic [2:0]        active_count;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .STEAL_GAP(GAP)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .key_valid    (key_valid),
        .key_on       (key_on),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .env_idle     (env_idle),
        .voice_gate   (voice_gate),
        .voice_key    (voice_key),
        .voice_retrig (voice_retrig),
        .steal_pulse  (steal_pulse),
        .drop_pulse   (drop_pulse),
        .active_count (active_count)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- behavioural model ----------------
    int          m_state [NV];
    int          m_key   [NV];
    int          lru_q   [$];
    bit          muting;
    int          mute_left;
    int          victim;
    int          pend;
    bit          m_ready;
    logic [NV-1:0] e_retrig;
    logic [NV-1:0] e_gate;
    bit          e_steal;
    bit          e_drop;
    int          e_active;
    bit          started = 0;

    function automatic void touch(input int v);
        for (int p = 0; p < lru_q.size(); p++) begin
            if (lru_q[p] == v) begin
                lru_q.delete(p);
                break;
            end
        end
        lru_q.push_front(v);
    endfunction

    function automatic int oldest_in(input int s);
        for (int p = lru_q.size() - 1; p >= 0; p--) begin
            if (m_state[lru_q[p]] == s) return lru_q[p];
        end
        return -1;
    endfunction

    task automatic model_step();
        int ns [NV];
        int hit;
        int fv;
        bit acc;
        e_retrig = '0;
        e_steal  = 0;
        e_drop   = 0;
        if (Reset) begin
            lru_q.delete();
            for (int i = 0; i < NV; i++) begin
                m_state[i] = M_FREE;
                m_key[i]   = 0;
                lru_q.push_back(i);
            end
            muting    = 0;
            mute_left = 0;
            m_ready   = 1;
        end else begin
            acc = key_valid && m_ready;
            ns  = m_state;
            for (int i = 0; i < NV; i++)
                if (m_state[i] == M_REL && env_idle[i]) ns[i] = M_FREE;
            if (muting) begin
                mute_left--;
                if (mute_left == 0) begin
                    m_key[victim]    = pend;
                    e_retrig[victim] = 1'b1;
                    touch(victim);
                    muting  = 0;
                    m_ready = 1;
                end
            end else if (acc) begin
                hit = -1;
                for (int i = 0; i < NV; i++)
                    if (m_state[i] == M_HELD && m_key[i] == int'(key_code)) hit = i;
                if (key_on) begin
                    if (hit >= 0) begin
                        e_retrig[hit] = 1'b1;
                    end else begin
                        fv = -1;
                        for (int i = NV - 1; i >= 0; i--)
                            if (m_state[i] == M_FREE) fv = i;
                        if (fv < 0) fv = oldest_in(M_REL);
                        if (fv >= 0) begin
                            ns[fv]       = M_HELD;
                            m_key[fv]    = int'(key_code);
                            e_retrig[fv] = 1'b1;
                            touch(fv);
                        end else begin
`ifdef VOICE_STEAL_EN
                            victim    = oldest_in(M_HELD);
                            pend      = int'(key_code);
                            muting    = 1;
                            mute_left = GAP;
                            m_ready   = 0;
                            e_steal   = 1;
`else
                            e_drop = 1;
`endif
                        end
                    end
                end else if (hit >= 0) begin
                    ns[hit] = M_REL;
                end
            end
            m_state = ns;
        end
        e_active = 0;
        for (int i = 0; i < NV; i++) begin
            e_gate[i] = (m_state[i] == M_HELD) && !(muting && i == victim);
            if (m_state[i] != M_FREE) e_active++;
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            model_step();
            started = 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (started) begin
                for (int i = 0; i < NV; i++) begin
                    check($sformatf("gate%0d", i), 32'(voice_gate[i]), 32'(e_gate[i]));
                    check($sformatf("key%0d", i), 32'(voice_key[i*KW +: KW]), m_key[i]);
                end
                check("retrig", 32'(voice_retrig), 32'(e_retrig));
                check("steal", 32'(steal_pulse), 32'(e_steal));
                check("drop", 32'(drop_pulse), 32'(e_drop));
                check("ready", 32'(key_ready), 32'(m_ready));
                check("active", 32'(active_count), e_active);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit on, input int code);
        int n = 0;
        while (key_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge Clk);
        end
        check("ready_wait", 32'(key_ready), 1);
        key_valid = 1'b1;
        key_on    = on;
        key_code  = code[KW-1:0];
        @(negedge Clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    logic [NV*KW-1:0] exp_k;
    int n;

    initial begin
        Reset     = 1'b1;
        key_valid = 1'b0;
        key_on    = 1'b0;
        key_code  = '0;
        env_idle  = '0;
        repeat (2) @(negedge Clk);
        check("rst_gate", 32'(voice_gate), 0);
        check("rst_key", 32'(voice_key), 0);
        check("rst_ready", 32'(key_ready), 1);
        check("rst_active", 32'(active_count), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Three key-ons fill voices 0..2.
        send(1, 10);
        send(1, 11);
        send(1, 12);
        check("on3_retrig", 32'(voice_retrig), 32'h4);
        check("on3_gate", 32'(voice_gate), 32'h7);
        exp_k = {6'd0, 6'd12, 6'd11, 6'd10};
        check("on3_key", 32'(voice_key), 32'(exp_k));
        check("on3_active", 32'(active_count), 3);

        // Release 11, then reclaim voice 1 and reuse it.
        send(0, 11);
        check("off11_gate", 32'(voice_gate), 32'h5);
        check("off11_active", 32'(active_count), 3);
        env_idle = 4'b0010;
        @(negedge Clk);
        env_idle = '0;
        check("reclaim_active", 32'(active_count), 2);
        send(1, 20);
        check("on20_key1", 32'(voice_key[11:6]), 20);
        check("on20_gate", 32'(voice_gate), 32'h7);
        check("on20_retrig", 32'(voice_retrig), 32'h2);

        // All four held, then one more key-on.
        pulse_reset();
        send(1, 10);
        send(1, 11);
        send(1, 12);
        send(1, 13);
        check("full_gate", 32'(voice_gate), 32'hF);
        check("full_active", 32'(active_count), 4);
        send(1, 30);
`ifdef VOICE_STEAL_EN
        check("steal_pulse", 32'(steal_pulse), 1);
        check("steal_gate", 32'(voice_gate), 32'hE);
        check("steal_ready", 32'(key_ready), 0);
        n = 0;
        while (key_ready === 1'b0 && n < 50) begin
            check("mute_gate0", 32'(voice_gate[0]), 0);
            n++;
            @(negedge Clk);
        end
        check("mute_len", n, GAP);
        check("steal_key0", 32'(voice_key[5:0]), 30);
        check("steal_done_gate", 32'(voice_gate), 32'hF);
        check("steal_retrig", 32'(voice_retrig), 32'h1);
`else
        check("drop_pulse", 32'(drop_pulse), 1);
        check("drop_gate", 32'(voice_gate), 32'hF);
        exp_k = {6'd13, 6'd12, 6'd11, 6'd10};
        check("drop_key", 32'(voice_key), 32'(exp_k));
        check("drop_retrig", 32'(voice_retrig), 0);
`endif
        @(negedge Clk);

        // A releasing voice is reused without a steal.
        pulse_reset();
        send(1, 10);
        send(1, 11);
        send(1, 12);
        send(1, 13);
        send(0, 12);
        check("off12_gate", 32'(voice_gate), 32'hB);
        send(1, 40);
        check("reuse_key2", 32'(voice_key[17:12]), 40);
        check("reuse_gate", 32'(voice_gate), 32'hF);
        check("reuse_steal", 32'(steal_pulse), 0);
        check("reuse_drop", 32'(drop_pulse), 0);
        check("reuse_active", 32'(active_count), 4);

        // Retrigger in place, then an unheld key-off, then env_idle on held voices.
        send(1, 10);
        check("retrig_in_place", 32'(voice_retrig), 32'h1);
        check("retrig_gate", 32'(voice_gate), 32'hF);
        send(0, 99);
        check("off99_gate", 32'(voice_gate), 32'hF);
        check("off99_retrig", 32'(voice_retrig), 0);
        env_idle = 4'b1111;
        repeat (2) @(negedge Clk);
        env_idle = '0;
        check("idle_held_active", 32'(active_count), 4);

        // Oldest releasing voice is chosen: voice 1 (key 11) is older than voice 3.
        send(0, 13);
        send(0, 11);
        send(1, 50);
        check("lru_rel_key1", 32'(voice_key[11:6]), 50);
        send(1, 51);
        check("lru_rel_key3", 32'(voice_key[23:18]), 51);
        check("lru_rel_gate", 32'(voice_gate), 32'hF);

        // Reset right after a key-on with every voice held (mid-mute when stealing).
        send(1, 60);
        @(negedge Clk);
        pulse_reset();
        check("rst_mid_gate", 32'(voice_gate), 0);
        check("rst_mid_ready", 32'(key_ready), 1);
        check("rst_mid_active", 32'(active_count), 0);
        check("rst_mid_key", 32'(voice_key), 0);
        repeat (GAP + 2) @(negedge Clk);
        check("post_rst_gate", 32'(voice_gate), 0);

        send(1, 7);
        check("after_rst_retrig", 32'(voice_retrig), 32'h1);
        check("after_rst_key0", 32'(voice_key[5:0]), 7);
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
